// File: rtl/paddle_position_counter_pkg.sv
`default_nettype none
// ============================================================================
// Module      : paddle_position_counter_pkg
// Description : Shared definitions for the paddle position counter:
//               control codes from the direction decoder, FSM state encoding
//               and the position width.
// Revision    : 1.0 - initial release
// ============================================================================
package paddle_position_counter_pkg;

  localparam int unsigned POS_W = 10;

  // Control codes produced by the button-to-direction decoder.
  // 2'b11 is illegal and is handled exactly like CTRL_HOLD.
  localparam logic [1:0] CTRL_LEFT  = 2'b00;
  localparam logic [1:0] CTRL_RIGHT = 2'b01;
  localparam logic [1:0] CTRL_HOLD  = 2'b10;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_MV_L = 2'd1,
    ST_MV_R = 2'd2
  } state_t;

endpackage : paddle_position_counter_pkg
`default_nettype wire

// File: rtl/paddle_position_counter_prescaler.sv
`default_nettype none
// ============================================================================
// Module      : tick_prescaler
// Description : Free-running divider producing a one-cycle strobe every
//               CLK_DIV enabled cycles. Reusable by other game timers.
// Ports       : clk     - system clock
//               rst_n   - synchronous active-low reset
//               i_en    - run enable; low holds the divider, no strobe
//               i_clr   - synchronous clear of the divider to 0
//               o_tick  - high in the cycle where divider == CLK_DIV-1
// Revision    : 1.0 - initial release
// ============================================================================
module tick_prescaler #(
  parameter int unsigned CLK_DIV = 250000
) (
  input  logic clk,
  input  logic rst_n,
  input  logic i_en,
  input  logic i_clr,
  output logic o_tick
);

  localparam int unsigned              c_DIV_W    = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam logic [c_DIV_W-1:0]       c_DIV_LAST = c_DIV_W'(CLK_DIV - 1);

  logic [c_DIV_W-1:0] r_div;
  logic               w_wrap;

  assign w_wrap = (r_div == c_DIV_LAST);
  // Strobe is suppressed while reset is held so nothing downstream moves.
  assign o_tick = rst_n & i_en & w_wrap;

  always_ff @(posedge clk) begin
    if (!rst_n || i_clr) begin
      r_div <= '0;
    end else if (i_en) begin
      r_div <= w_wrap ? '0 : r_div + 1'b1;
    end
  end

endmodule : tick_prescaler
`default_nettype wire

// File: rtl/paddle_position_counter.sv
`default_nettype none
// ============================================================================
// Module      : paddle_position_counter
// Description : Owns the 10-bit horizontal paddle position. On every
//               prescaler tick the position steps left/right/holds according
//               to the decoder control code, clamped to [POS_MIN, POS_MAX].
//               Optional acceleration (macro PADDLE_ACCEL_EN) doubles the
//               step after ACCEL_TICKS same-direction ticks and quadruples it
//               after 2*ACCEL_TICKS.
// Ports       : clk      - system clock
//               rst_n    - synchronous active-low reset
//               ctrl     - 00 left, 01 right, 10/11 hold
//               en       - run enable (freezes prescaler and position)
//               recenter - return to POS_INIT next cycle (beats a tick)
//               cnt_val  - registered position
//               moving   - registered, high in MV_L / MV_R
//               at_limit - registered, cnt_val at POS_MIN or POS_MAX
//               tick     - one-cycle movement strobe
// Revision    : 1.0 - initial release
// ============================================================================
module paddle_position_counter
  import paddle_position_counter_pkg::*;
#(
  parameter int unsigned CLK_DIV     = 250000,
  parameter int unsigned POS_MIN     = 15,
  parameter int unsigned POS_MAX     = 624,
  parameter int unsigned POS_INIT    = 320,
  parameter int unsigned STEP        = 1,
  parameter int unsigned ACCEL_TICKS = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [1:0]       ctrl,
  input  logic             en,
  input  logic             recenter,
  output logic [POS_W-1:0] cnt_val,
  output logic             moving,
  output logic             at_limit,
  output logic             tick
);

  // One extra bit of headroom so left/right steps never wrap before clamping.
  localparam int unsigned          c_AW       = POS_W + 1;
  localparam logic [c_AW-1:0]      c_POS_MIN  = c_AW'(POS_MIN);
  localparam logic [c_AW-1:0]      c_POS_MAX  = c_AW'(POS_MAX);
  localparam logic [POS_W-1:0]     c_POS_INIT = POS_W'(POS_INIT);
  localparam logic                 c_INIT_LIM = (POS_INIT == POS_MIN) || (POS_INIT == POS_MAX);
  localparam int unsigned          c_RUN_MAX  = 2 * ACCEL_TICKS;
  localparam int unsigned          c_RUN_W    = $clog2(c_RUN_MAX + 1);

  state_t              r_state;
  state_t              w_state_nxt;
  logic [POS_W-1:0]    r_pos;
  logic [POS_W-1:0]    w_pos_nxt;
  logic [c_AW-1:0]     w_raw;
  logic [c_AW-1:0]     w_step;
  logic [c_RUN_W-1:0]  w_run_idx;
  logic                r_moving;
  logic                r_at_limit;
  logic                w_tick;

  tick_prescaler #(
    .CLK_DIV (CLK_DIV)
  ) u_prescaler (
    .clk    (clk),
    .rst_n  (rst_n),
    .i_en   (en),
    .i_clr  (recenter),
    .o_tick (w_tick)
  );

  // Next state: only tick cycles sample ctrl; reversal is allowed directly.
  always_comb begin
    w_state_nxt = r_state;
    if (w_tick) begin
      case (ctrl)
        CTRL_LEFT:  w_state_nxt = ST_MV_L;
        CTRL_RIGHT: w_state_nxt = ST_MV_R;
        default:    w_state_nxt = ST_IDLE;
      endcase
    end
  end

`ifdef PADDLE_ACCEL_EN
  // Count of earlier consecutive ticks in the current direction. A tick that
  // continues the same MV_ state uses it; anything else starts from zero.
  logic [c_RUN_W-1:0] r_run;

  always_comb begin
    w_run_idx = '0;
    if ((w_state_nxt == r_state) && (w_state_nxt != ST_IDLE)) begin
      w_run_idx = r_run;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n || recenter) begin
      r_run <= '0;
    end else if (w_tick) begin
      if (w_state_nxt == ST_IDLE) begin
        r_run <= '0;
      end else if (w_run_idx == c_RUN_W'(c_RUN_MAX)) begin
        r_run <= w_run_idx;
      end else begin
        r_run <= w_run_idx + 1'b1;
      end
    end
  end
`else
  // Without acceleration the index is constant and the step mux folds away.
  assign w_run_idx = '0;
`endif

  always_comb begin
    w_step = c_AW'(STEP);
    if (w_run_idx >= c_RUN_W'(c_RUN_MAX)) begin
      w_step = c_AW'(4 * STEP);
    end else if (w_run_idx >= c_RUN_W'(ACCEL_TICKS)) begin
      w_step = c_AW'(2 * STEP);
    end
  end

  // Position update. Hold ticks still pass through the clamp so an
  // out-of-range position is pulled back on the next tick.
  always_comb begin
    w_raw     = {1'b0, r_pos};
    w_pos_nxt = r_pos;
    if (w_tick) begin
      case (ctrl)
        CTRL_LEFT:  w_raw = ({1'b0, r_pos} > w_step) ? ({1'b0, r_pos} - w_step) : '0;
        CTRL_RIGHT: w_raw = {1'b0, r_pos} + w_step;
        default:    w_raw = {1'b0, r_pos};
      endcase
      if (w_raw < c_POS_MIN) begin
        w_pos_nxt = c_POS_MIN[POS_W-1:0];
      end else if (w_raw > c_POS_MAX) begin
        w_pos_nxt = c_POS_MAX[POS_W-1:0];
      end else begin
        w_pos_nxt = w_raw[POS_W-1:0];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n || recenter) begin
      r_state    <= ST_IDLE;
      r_pos      <= c_POS_INIT;
      r_moving   <= 1'b0;
      r_at_limit <= c_INIT_LIM;
    end else begin
      r_state    <= w_state_nxt;
      r_pos      <= w_pos_nxt;
      r_moving   <= (w_state_nxt != ST_IDLE);
      r_at_limit <= ({1'b0, w_pos_nxt} == c_POS_MIN) || ({1'b0, w_pos_nxt} == c_POS_MAX);
    end
  end

  assign cnt_val  = r_pos;
  assign moving   = r_moving;
  assign at_limit = r_at_limit;
  assign tick     = w_tick;

endmodule : paddle_position_counter
`default_nettype wire

// File: tb/tb_paddle_position_counter.sv
`default_nettype none
// ============================================================================
// Module      : tb_paddle_position_counter
// Description : Self-checking bench. Three DUTs share stimulus and differ only
//               in POS_INIT (320 / 16 / 623) so both clamp limits are reachable
//               through recenter. A behavioural model tracks every DUT.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_paddle_position_counter;

  localparam int CLK_DIV = 4;
  localparam int POS_MIN = 15;
  localparam int POS_MAX = 624;
  localparam int STEP    = 1;
  localparam int ACCEL   = 2;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [1:0] ctrl = 2'b10;
  logic       en = 1'b0;
  logic       recenter = 1'b0;
  logic [9:0] cnt_o [3];
  logic       mov_o [3];
  logic       lim_o [3];
  logic       tck_o [3];

  always #5 clk = ~clk;

  paddle_position_counter #(.CLK_DIV(CLK_DIV), .POS_MIN(POS_MIN), .POS_MAX(POS_MAX),
    .POS_INIT(320), .STEP(STEP), .ACCEL_TICKS(ACCEL)) u_dut0 (
    .clk(clk), .rst_n(rst_n), .ctrl(ctrl), .en(en), .recenter(recenter),
    .cnt_val(cnt_o[0]), .moving(mov_o[0]), .at_limit(lim_o[0]), .tick(tck_o[0]));
  paddle_position_counter #(.CLK_DIV(CLK_DIV), .POS_MIN(POS_MIN), .POS_MAX(POS_MAX),
    .POS_INIT(16), .STEP(STEP), .ACCEL_TICKS(ACCEL)) u_dut1 (
    .clk(clk), .rst_n(rst_n), .ctrl(ctrl), .en(en), .recenter(recenter),
    .cnt_val(cnt_o[1]), .moving(mov_o[1]), .at_limit(lim_o[1]), .tick(tck_o[1]));
  paddle_position_counter #(.CLK_DIV(CLK_DIV), .POS_MIN(POS_MIN), .POS_MAX(POS_MAX),
    .POS_INIT(623), .STEP(STEP), .ACCEL_TICKS(ACCEL)) u_dut2 (
    .clk(clk), .rst_n(rst_n), .ctrl(ctrl), .en(en), .recenter(recenter),
    .cnt_val(cnt_o[2]), .moving(mov_o[2]), .at_limit(lim_o[2]), .tick(tck_o[2]));

  int checks = 0;
  int failures = 0;

  // Reference model: position, direction (0 idle, 1 left, 2 right), run length
  int c_init [3] = '{320, 16, 623};
  int m_pos [3];
  int m_dir [3];
  int m_run [3];
  int m_div;
  logic exp_tick;
  logic obs_tick [3];

  function automatic int step_for(input int idx);
`ifdef PADDLE_ACCEL_EN
    if (idx >= 2 * ACCEL) return 4 * STEP;
    if (idx >= ACCEL) return 2 * STEP;
    return STEP;
`else
    return STEP + 0 * idx;
`endif
  endfunction

  function automatic int clampi(input int p);
    if (p < POS_MIN) return POS_MIN;
    if (p > POS_MAX) return POS_MAX;
    return p;
  endfunction

  // Applies one clock of stimulus and advances the model by the same clock.
  task automatic cycle(input logic [1:0] c, input logic e, input logic rc, input logic rs);
    int d, idx;
    ctrl = c; en = e; recenter = rc; rst_n = rs;
    #1;
    exp_tick = rs && e && (m_div == CLK_DIV - 1);
    for (int i = 0; i < 3; i++) obs_tick[i] = tck_o[i];
    @(posedge clk);
    if (!rs || rc) begin
      m_div = 0;
      for (int i = 0; i < 3; i++) begin m_pos[i] = c_init[i]; m_dir[i] = 0; m_run[i] = 0; end
    end else if (e) begin
      if (m_div == CLK_DIV - 1) begin
        m_div = 0;
        d = (c == 2'b00) ? 1 : (c == 2'b01) ? 2 : 0;
        for (int i = 0; i < 3; i++) begin
          if (d == 0) begin
            m_dir[i] = 0; m_run[i] = 0; m_pos[i] = clampi(m_pos[i]);
          end else begin
            idx = (d == m_dir[i]) ? m_run[i] : 0;
            m_pos[i] = clampi((d == 1) ? m_pos[i] - step_for(idx) : m_pos[i] + step_for(idx));
            m_dir[i] = d;
            m_run[i] = (idx + 1 > 2 * ACCEL) ? 2 * ACCEL : idx + 1;
          end
        end
      end else begin
        m_div++;
      end
    end
    #1;
  endtask

  task automatic test_reset();
    cycle(2'b10, 1'b1, 1'b0, 1'b0);
    cycle(2'b10, 1'b1, 1'b0, 1'b0);
    rst_n = 1'b1; #1;
    for (int i = 0; i < 3; i++) begin
      checks++; if (cnt_o[i] !== 10'(c_init[i])) begin failures++; $display("FAIL reset_cnt dut%0d got=%0d exp=%0d", i, cnt_o[i], c_init[i]); end
      checks++; if (mov_o[i] !== 1'b0) begin failures++; $display("FAIL reset_moving dut%0d got=%b exp=0", i, mov_o[i]); end
      checks++; if (lim_o[i] !== 1'b0) begin failures++; $display("FAIL reset_at_limit dut%0d got=%b exp=0", i, lim_o[i]); end
      checks++; if (tck_o[i] !== 1'b0) begin failures++; $display("FAIL reset_tick dut%0d got=%b exp=0", i, tck_o[i]); end
    end
  endtask

  task automatic test_hold();
    int nt = 0;
    for (int k = 0; k < 12; k++) begin
      cycle(2'b10, 1'b1, 1'b0, 1'b1);
      if (obs_tick[0]) nt++;
      checks++; if (obs_tick[0] !== exp_tick) begin failures++; $display("FAIL hold_tick cyc%0d got=%b exp=%b", k, obs_tick[0], exp_tick); end
      checks++; if (cnt_o[0] !== 10'd320 || mov_o[0] !== 1'b0) begin failures++; $display("FAIL hold_pos cyc%0d got=%0d/%b exp=320/0", k, cnt_o[0], mov_o[0]); end
    end
    checks++; if (nt != 3) begin failures++; $display("FAIL hold_tick_count got=%0d exp=3", nt); end
  endtask

  task automatic test_right();
    int nt = 0;
    for (int k = 0; k < 40 && nt < 5; k++) begin
      cycle(2'b01, 1'b1, 1'b0, 1'b1);
      if (exp_tick) nt++;
      checks++; if (cnt_o[0] !== 10'(m_pos[0]) || mov_o[0] !== (m_dir[0] != 0)) begin
        failures++; $display("FAIL right_step cyc%0d got=%0d/%b exp=%0d/%b", k, cnt_o[0], mov_o[0], m_pos[0], m_dir[0] != 0); end
    end
`ifdef PADDLE_ACCEL_EN
    checks++; if (cnt_o[0] !== 10'd330) begin failures++; $display("FAIL right_final got=%0d exp=330", cnt_o[0]); end
`else
    checks++; if (cnt_o[0] !== 10'd325) begin failures++; $display("FAIL right_final got=%0d exp=325", cnt_o[0]); end
`endif
    checks++; if (mov_o[0] !== 1'b1) begin failures++; $display("FAIL right_moving got=%b exp=1", mov_o[0]); end
  endtask

  task automatic test_limits();
    cycle(2'b10, 1'b1, 1'b1, 1'b1);
    for (int k = 0; k < 12; k++) begin
      cycle(2'b00, 1'b1, 1'b0, 1'b1);
      checks++; if (cnt_o[1] !== 10'(m_pos[1]) || lim_o[1] !== (m_pos[1] == POS_MIN)) begin
        failures++; $display("FAIL low_limit cyc%0d got=%0d/%b exp=%0d/%b", k, cnt_o[1], lim_o[1], m_pos[1], m_pos[1] == POS_MIN); end
    end
    checks++; if (cnt_o[1] !== 10'd15 || lim_o[1] !== 1'b1) begin failures++; $display("FAIL low_final got=%0d/%b exp=15/1", cnt_o[1], lim_o[1]); end
    cycle(2'b10, 1'b1, 1'b1, 1'b1);
    for (int k = 0; k < 12; k++) begin
      cycle(2'b01, 1'b1, 1'b0, 1'b1);
      checks++; if (cnt_o[2] !== 10'(m_pos[2]) || lim_o[2] !== (m_pos[2] == POS_MAX)) begin
        failures++; $display("FAIL high_limit cyc%0d got=%0d/%b exp=%0d/%b", k, cnt_o[2], lim_o[2], m_pos[2], m_pos[2] == POS_MAX); end
    end
    checks++; if (cnt_o[2] !== 10'd624 || lim_o[2] !== 1'b1) begin failures++; $display("FAIL high_final got=%0d/%b exp=624/1", cnt_o[2], lim_o[2]); end
  endtask

  task automatic test_recenter_tick();
    cycle(2'b10, 1'b1, 1'b1, 1'b1);
    for (int k = 0; k < 3; k++) cycle(2'b01, 1'b1, 1'b0, 1'b1);
    cycle(2'b01, 1'b1, 1'b1, 1'b1);
    checks++; if (obs_tick[0] !== 1'b1) begin failures++; $display("FAIL rc_tick_coincide got=%b exp=1", obs_tick[0]); end
    checks++; if (cnt_o[0] !== 10'd320 || mov_o[0] !== 1'b0) begin failures++; $display("FAIL rc_priority got=%0d/%b exp=320/0", cnt_o[0], mov_o[0]); end
    for (int k = 0; k < 4; k++) begin
      cycle(2'b01, 1'b1, 1'b0, 1'b1);
      checks++; if (obs_tick[0] !== (k == 3)) begin failures++; $display("FAIL rc_div_restart cyc%0d got=%b exp=%b", k, obs_tick[0], k == 3); end
    end
    checks++; if (cnt_o[0] !== 10'd321) begin failures++; $display("FAIL rc_after got=%0d exp=321", cnt_o[0]); end
  endtask

  task automatic test_en_low();
    for (int k = 0; k < 10; k++) begin
      cycle(2'b01, 1'b0, 1'b0, 1'b1);
      checks++; if (obs_tick[0] !== 1'b0 || cnt_o[0] !== 10'(m_pos[0])) begin
        failures++; $display("FAIL en_low cyc%0d got=%b/%0d exp=0/%0d", k, obs_tick[0], cnt_o[0], m_pos[0]); end
    end
  endtask

  task automatic test_illegal();
    for (int k = 0; k < 9; k++) begin
      cycle(2'b11, 1'b1, 1'b0, 1'b1);
      checks++; if (cnt_o[0] !== 10'(m_pos[0]) || (k > 4 && mov_o[0] !== 1'b0)) begin
        failures++; $display("FAIL illegal_hold cyc%0d got=%0d/%b exp=%0d", k, cnt_o[0], mov_o[0], m_pos[0]); end
    end
    checks++; if (mov_o[0] !== 1'b0) begin failures++; $display("FAIL illegal_moving got=%b exp=0", mov_o[0]); end
  endtask

  task automatic test_reset_mid();
    int k = 0;
    cycle(2'b10, 1'b1, 1'b1, 1'b1);
    while (m_pos[0] < 400 && k < 2000) begin cycle(2'b01, 1'b1, 1'b0, 1'b1); k++; end
    checks++; if (cnt_o[0] !== 10'(m_pos[0]) || m_pos[0] < 400) begin failures++; $display("FAIL mid_reach got=%0d exp=%0d", cnt_o[0], m_pos[0]); end
    cycle(2'b01, 1'b1, 1'b0, 1'b0);
    checks++; if (cnt_o[0] !== 10'd320 || mov_o[0] !== 1'b0 || lim_o[0] !== 1'b0 || tck_o[0] !== 1'b0) begin
      failures++; $display("FAIL mid_reset got=%0d/%b/%b/%b exp=320/0/0/0", cnt_o[0], mov_o[0], lim_o[0], tck_o[0]); end
  endtask

  task automatic test_random();
    logic [1:0] c;
    logic e, rc, rs;
    for (int k = 0; k < 400; k++) begin
      c  = 2'($urandom_range(0, 3));
      e  = ($urandom_range(0, 9) != 0);
      rc = ($urandom_range(0, 39) == 0);
      rs = ($urandom_range(0, 99) != 0);
      cycle(c, e, rc, rs);
      for (int i = 0; i < 3; i++) begin
        checks++;
        if (cnt_o[i] !== 10'(m_pos[i]) || mov_o[i] !== (m_dir[i] != 0) ||
            lim_o[i] !== (m_pos[i] == POS_MIN || m_pos[i] == POS_MAX) || obs_tick[i] !== exp_tick) begin
          failures++;
          $display("FAIL random cyc%0d dut%0d got=%0d/%b/%b/%b exp=%0d/%b/%b/%b", k, i, cnt_o[i], mov_o[i], lim_o[i],
                   obs_tick[i], m_pos[i], m_dir[i] != 0, m_pos[i] == POS_MIN || m_pos[i] == POS_MAX, exp_tick);
        end
      end
    end
  endtask

`ifdef PADDLE_ACCEL_EN
  task automatic test_accel();
    int exp_seq [5] = '{321, 322, 324, 326, 330};
    int nt = 0;
    cycle(2'b10, 1'b1, 1'b1, 1'b1);
    for (int k = 0; k < 40 && nt < 5; k++) begin
      cycle(2'b01, 1'b1, 1'b0, 1'b1);
      if (exp_tick) begin
        checks++; if (cnt_o[0] !== 10'(exp_seq[nt])) begin failures++; $display("FAIL accel_seq tick%0d got=%0d exp=%0d", nt, cnt_o[0], exp_seq[nt]); end
        nt++;
      end
    end
    for (int k = 0; k < 4; k++) cycle(2'b10, 1'b1, 1'b0, 1'b1);
    for (int k = 0; k < 4; k++) cycle(2'b01, 1'b1, 1'b0, 1'b1);
    checks++; if (cnt_o[0] !== 10'd331) begin failures++; $display("FAIL accel_restart got=%0d exp=331", cnt_o[0]); end
  endtask
`endif

  initial begin
    m_div = 0;
    for (int i = 0; i < 3; i++) begin m_pos[i] = c_init[i]; m_dir[i] = 0; m_run[i] = 0; end
    @(posedge clk); #1;
    test_reset();
    test_hold();
    test_right();
    test_limits();
    test_recenter_tick();
    test_en_low();
    test_illegal();
    test_reset_mid();
`ifdef PADDLE_ACCEL_EN
    test_accel();
`endif
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule : tb_paddle_position_counter
`default_nettype wire

// File: doc/paddle_position_counter.md
Name: paddle_position_counter

Overview:
- Downstream stage of the button-to-direction decoder; consumes its 2-bit control code and owns the 10-bit horizontal position fed back to it as the count value.
- Internal prescaler produces a movement tick. On each tick the position steps left, steps right or holds, clamped to [POS_MIN, POS_MAX].
- Output drives the sprite/paddle renderer and closes the loop back to the decoder.

Parameters:
- CLK_DIV, 250000, clock cycles per movement tick (≥2)
- POS_MIN, 15, lowest legal position
- POS_MAX, 624, highest legal position
- POS_INIT, 320, position after reset or recenter
- STEP, 1, base pixels moved per tick
- ACCEL_TICKS, 16, consecutive same-direction ticks before step doubles (used only with the optional feature)

Ports:
- clk  in  1  system clock
- rst_n  in  1  synchronous active-low reset
- ctrl  in  2  control code: 00 = move left (decrement), 01 = move right (increment), 10 = hold, 11 = hold (illegal, treated as hold)
- en  in  1  run enable; low freezes prescaler and position
- recenter  in  1  single-cycle request to return to POS_INIT
- cnt_val  out  10  current position, registered
- moving  out  1  high while FSM is in MV_L or MV_R
- at_limit  out  1  high when cnt_val == POS_MIN or cnt_val == POS_MAX
- tick  out  1  one-cycle movement strobe, for renderer sync

Behaviour:
- Reset (rst_n low at posedge clk): cnt_val = POS_INIT, divider = 0, FSM = IDLE, moving = 0, tick = 0, at_limit recomputed (0 for defaults), accel state cleared.
- Prescaler: runs only when en = 1. Counts 0..CLK_DIV-1; tick = 1 for exactly the cycle in which divider == CLK_DIV-1; divider then wraps to 0. With en = 0, divider holds and tick = 0.
- FSM states IDLE, MV_L, MV_R. Sampled only on tick cycles: ctrl 00 → MV_L, 01 → MV_R, 10/11 → IDLE. Direct reversal MV_L↔MV_R is allowed in one tick.
- Position update (same tick cycle, uses that cycle's ctrl):
  - left: cnt_val ← max(cnt_val − step, POS_MIN)
  - right: cnt_val ← min(cnt_val + step, POS_MAX)
  - hold: unchanged
- Latency: new cnt_val is visible the cycle after the tick cycle.
- Arithmetic is done 11 bits wide, so underflow or overflow never wraps; result is clamped before writeback.
- Out-of-range position (only possible through parameter misuse) clamps into range on the next tick, regardless of direction.
- recenter = 1: next cycle cnt_val = POS_INIT, divider = 0, FSM = IDLE, accel cleared. Takes priority over a coincident tick; no movement applied that cycle. Honoured even when en = 0.
- rst_n has priority over recenter.
- moving and at_limit are registered, derived from next-state values, so they align with cnt_val.

Optional Feature:
- Macro: PADDLE_ACCEL_EN.
- Defined:
  - Counts consecutive ticks in the same MV_ state, saturating.
  - step = STEP for ticks 0..ACCEL_TICKS-1, 2×STEP from ACCEL_TICKS, 4×STEP from 2×ACCEL_TICKS.
  - Any IDLE tick, direction change, recenter or reset returns step to STEP.
  - Clamping is unchanged.
- Undefined: step is always STEP and no accel counter is synthesised.

Decomposition:
- Shared package: ctrl code constants (CTRL_LEFT = 2'b00, CTRL_RIGHT = 2'b01, CTRL_HOLD = 2'b10), FSM state encoding, POS_W = 10.
- One natural sub-module, tick_prescaler (divider plus en gating plus clear input), reusable by the other game timers.
- Clamp arithmetic stays inline.

Test Plan:
- CLK_DIV = 4. Reset, then hold ctrl = 10 → cnt_val = 320, moving = 0, tick every 4th cycle, no position change.
- ctrl = 01 for 5 ticks → cnt_val 321..325 across successive post-tick cycles, moving = 1 from the first post-tick cycle.
- Force position to 16 via recenter with POS_INIT = 16, then ctrl = 00 for 3 ticks → 15, 15, 15, with at_limit = 1 once 15 is reached. Same check at 623 with ctrl = 01 → 624, at_limit = 1.
- Assert recenter in the same cycle as a tick while ctrl = 01 → cnt_val = 320 next cycle, no increment, divider restarts at 0. Drop en for 10 cycles → no tick, cnt_val constant.
- ctrl = 11 → treated as hold. Drop rst_n mid-run at cnt_val = 400 → 320 next cycle, all outputs at reset values.
- With PADDLE_ACCEL_EN, ACCEL_TICKS = 2, ctrl = 01 from 320 → 321, 322, 324, 326, 330. A hold tick then 01 again → step returns to 1.
